// File: rtl/note_phase_pkg.sv
// Shared types and constants for note_phase_gen: FSM states, octave-10 FTW table,
// width defaults and the note-number to FTW helper.
package note_phase_pkg;

    localparam int ACC_W_DEF   = 32;
    localparam int PHASE_W_DEF = 10;
    localparam int OCT_REF     = 10;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        LOOKUP
    } state_e;

    // FTWs of MIDI notes 120..131 at 48 kHz; lower octaves are right shifts of these.
    localparam logic [31:0] BASE [12] = '{
        32'd749115498,  32'd793660223,  32'd840853716,  32'd890853480,
        32'd943826385,  32'd999949222,  32'd1059409297, 32'd1122405052,
        32'd1189146729, 32'd1259857069, 32'd1334772074, 32'd1414141751
    };

    function automatic logic [31:0] note_ftw(input logic [3:0] rem, input logic [3:0] oct);
        return BASE[rem] >> (OCT_REF - int'(oct));
    endfunction

endpackage

// File: rtl/note_phase_gen_if.sv
// Note event handshake between the MIDI event decoder (master) and note_phase_gen (slave).
interface note_phase_gen_if;

    logic       note_valid;
    logic       note_ready;
    logic       note_on;
    logic [6:0] note_num;

    modport master (
        output note_valid,
        output note_on,
        output note_num,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_on,
        input  note_num,
        output note_ready
    );

endinterface

// File: rtl/note_divmod12.sv
// Iterative divide-by-12 of a MIDI note number: one subtraction per cycle,
// done is asserted on the cycle rem/oct hold the final quotient/remainder.
module note_divmod12 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] num,
    output logic       busy,
    output logic       done,
    output logic [3:0] rem,
    output logic [3:0] oct
);

    logic [6:0] rem_q, rem_d;
    logic [3:0] oct_q, oct_d;
    logic       busy_q, busy_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        rem_d  = rem_q;
        oct_d  = oct_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = num;
            oct_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (rem_q >= 7'd12) begin
                rem_d = rem_q - 7'd12;
                oct_d = oct_q + 4'd1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            rem_q  <= '0;
            oct_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            oct_q  <= oct_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (rem_q < 7'd12);
    assign rem  = rem_q[3:0];
    assign oct  = oct_q;

endmodule

// File: rtl/note_phase_gen.sv
// Per-voice note-to-phase generator: note number -> FTW -> phase accumulator stepped on sample_tick.
// Optional portamento between legato notes is compiled in with NOTE_PHASE_GLIDE_EN.
module note_phase_gen
    import note_phase_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF
`ifdef NOTE_PHASE_GLIDE_EN
    ,
    parameter int GLIDE_SHIFT = 8
`endif
) (
    input  logic               clk,
    input  logic               reset,
    note_phase_gen_if.slave    note,
    input  logic               sample_tick,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               gate
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   cur_ftw_q, cur_ftw_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               phase_valid_q, phase_valid_d;
    logic               gate_q, gate_d;
    logic               div_start, div_busy, div_done;
    logic [3:0]         div_rem, div_oct;
    logic [ACC_W-1:0]   lookup_ftw;
`ifdef NOTE_PHASE_GLIDE_EN
    logic [ACC_W-1:0]      tgt_ftw_q, tgt_ftw_d;
    logic signed [ACC_W:0] glide_diff, glide_step;
`endif

    note_divmod12 u_divmod (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .num   (note.note_num),
        .busy  (div_busy),
        .done  (div_done),
        .rem   (div_rem),
        .oct   (div_oct)
    );

    assign note.note_ready = (state_q == IDLE);
    assign lookup_ftw      = ACC_W'(note_ftw(div_rem, div_oct));

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cur_ftw_d     = cur_ftw_q;
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        gate_d        = gate_q;
        div_start     = 1'b0;
`ifdef NOTE_PHASE_GLIDE_EN
        tgt_ftw_d  = tgt_ftw_q;
        glide_diff = $signed({1'b0, tgt_ftw_q}) - $signed({1'b0, cur_ftw_q});
        glide_step = glide_diff >>> GLIDE_SHIFT;
`endif
        // The add uses the FTW in force before this cycle; a LOOKUP restart below overrides it.
        if (sample_tick) begin
            acc_d = acc_q + cur_ftw_q;
`ifdef NOTE_PHASE_GLIDE_EN
            cur_ftw_d = (glide_step == '0) ? tgt_ftw_q : cur_ftw_q + glide_step[ACC_W-1:0];
`endif
        end

        case (state_q)
            IDLE: begin
                if (note.note_valid) begin
                    if (note.note_on) begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end else begin
                        gate_d = 1'b0;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = LOOKUP;
                end else if (!div_busy) begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
`ifdef NOTE_PHASE_GLIDE_EN
                tgt_ftw_d = lookup_ftw;
                if (!gate_q) begin
                    acc_d     = '0;
                    cur_ftw_d = lookup_ftw;
                end
`else
                cur_ftw_d = lookup_ftw;
                if (!gate_q) begin
                    acc_d = '0;
                end
`endif
                gate_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (sample_tick) begin
            phase_valid_d = 1'b1;
            phase_d       = acc_d[ACC_W-1 -: PHASE_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cur_ftw_q     <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            gate_q        <= 1'b0;
`ifdef NOTE_PHASE_GLIDE_EN
            tgt_ftw_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cur_ftw_q     <= cur_ftw_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            gate_q        <= gate_d;
`ifdef NOTE_PHASE_GLIDE_EN
            tgt_ftw_q     <= tgt_ftw_d;
`endif
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign gate        = gate_q;

endmodule

// File: tb/tb_note_phase_gen.sv
// Self-checking bench for note_phase_gen: directed note scenarios with hand-computed phases,
// then random traffic, all compared every cycle against an event-level reference model.
module tb_note_phase_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_tick = 1'b0;
    logic [9:0] phase;
    logic       phase_valid;
    logic       gate;

    note_phase_gen_if nif ();

    note_phase_gen dut (
        .clk         (clk),
        .reset       (reset),
        .note        (nif),
        .sample_tick (sample_tick),
        .phase       (phase),
        .phase_valid (phase_valid),
        .gate        (gate)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: FTW of note n = table[n mod 12] >> (10 - n div 12).
    bit [31:0] ref_base [12] = '{
        32'd749115498,  32'd793660223,  32'd840853716,  32'd890853480,
        32'd943826385,  32'd999949222,  32'd1059409297, 32'd1122405052,
        32'd1189146729, 32'd1259857069, 32'd1334772074, 32'd1414141751
    };

    function automatic bit [31:0] ref_ftw(input int n);
        return ref_base[n % 12] >> (10 - n / 12);
    endfunction

    // Event-level model: an accepted note-on schedules its FTW to land on cycle
    // accept + octave + 2, and the block is busy until then.
    bit [31:0] m_acc = '0, m_cur = '0, m_tgt = '0, m_pend = '0, m_old_cur;
    bit        m_gate = 1'b0, m_ready = 1'b1, m_pv = 1'b0, m_old_gate;
    bit [9:0]  m_phase = '0;
    int        cyc = 0, lookup_at = -1, busy_until = -1;
    longint    g_step;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_acc = '0; m_cur = '0; m_tgt = '0; m_gate = 1'b0;
            m_ready = 1'b1; m_pv = 1'b0; m_phase = '0;
            lookup_at = -1; busy_until = -1;
        end else begin
            m_old_gate = m_gate;
            m_old_cur  = m_cur;
            m_pv       = 1'b0;
            if (sample_tick) begin
                m_acc = m_acc + m_old_cur;
`ifdef NOTE_PHASE_GLIDE_EN
                g_step = (longint'(m_tgt) - longint'(m_cur)) >>> 8;
                if (g_step == 0) m_cur = m_tgt;
                else m_cur = m_cur + 32'(g_step);
`endif
            end
            if (cyc == lookup_at) begin
                m_tgt = m_pend;
`ifndef NOTE_PHASE_GLIDE_EN
                m_cur = m_pend;
`endif
                if (!m_old_gate) begin
                    m_acc = '0;
                    m_cur = m_pend;
                end
                m_gate = 1'b1;
            end
            if (sample_tick) begin
                m_pv    = 1'b1;
                m_phase = m_acc[31:22];
            end
            if (m_ready && nif.note_valid) begin
                if (nif.note_on) begin
                    m_pend     = ref_ftw(int'(nif.note_num));
                    lookup_at  = cyc + int'(nif.note_num) / 12 + 2;
                    busy_until = lookup_at;
                end else begin
                    m_gate = 1'b0;
                end
            end
            m_ready = (cyc + 1 > busy_until);
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("phase", phase, m_phase);
            check("phase_valid", phase_valid, m_pv);
            check("gate", gate, m_gate);
            check("note_ready", nif.note_ready, m_ready);
        end
    end

    task automatic note_event(input bit on, input int num);
        nif.note_valid = 1'b1;
        nif.note_on    = on;
        nif.note_num   = 7'(num);
        @(negedge clk);
        nif.note_valid = 1'b0;
    endtask

    task automatic wait_ready(output int low);
        low = 0;
        while (!nif.note_ready && low < 50) begin
            low++;
            @(negedge clk);
        end
        check("note_ready_returns", nif.note_ready, 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    int low;

    initial begin
        nif.note_valid = 1'b0;
        nif.note_on    = 1'b0;
        nif.note_num   = '0;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;

        // Reset held while inputs toggle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nif.note_valid = 1'($urandom);
            nif.note_on    = 1'($urandom);
            nif.note_num   = 7'($urandom_range(0, 127));
            sample_tick    = 1'($urandom);
        end
        @(negedge clk);
        nif.note_valid = 1'b0;
        sample_tick    = 1'b0;
        check("rst_phase", phase, 0);
        check("rst_phase_valid", phase_valid, 0);
        check("rst_gate", gate, 0);
        check("rst_ready", nif.note_ready, 1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_phase", phase, 0);
        check("idle_ready", nif.note_ready, 1);

        // Note 69 from rest.
        note_event(1'b1, 69);
        wait_ready(low);
        check("ready_low_69", low, 7);
        ticks(1);
        check("phase_tick1_69", phase, 9);
        ticks(999);
        check("phase_tick1000_69", phase, 170);

        // Note-off keeps the phase running.
        note_event(1'b0, 0);
        check("gate_after_off", gate, 0);
        ticks(1);
        check("phase_release", phase, 180);

        // Note 0 (lowest octave), restarted from zero.
        note_event(1'b1, 0);
        wait_ready(low);
        check("ready_low_0", low, 2);
        ticks(1000);
        check("phase_note0", phase, 174);

        // Note 127 (top octave).
        note_event(1'b0, 0);
        note_event(1'b1, 127);
        wait_ready(low);
        check("ready_low_127", low, 12);
        ticks(1);
        check("phase_note127_t1", phase, 267);
        ticks(2);
        check("phase_note127_t3", phase, 802);

        // Legato note-on with a tick on the LOOKUP cycle: that tick uses the old FTW.
        note_event(1'b1, 69);
        repeat (6) @(negedge clk);
        check("ready_low_at_lookup", nif.note_ready, 0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("phase_lookup_tick_old_ftw", phase, 46);
        check("gate_legato", gate, 1);
        ticks(1);
        check("phase_after_lookup_new_ftw", phase, 55);

        // Non-legato note-on with a tick on the LOOKUP cycle: the clear wins.
        note_event(1'b0, 0);
        note_event(1'b1, 5);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("phase_clear_on_lookup", phase, 0);
        wait_ready(low);
        ticks(2000);
        check("phase_note5", phase, 465);

        // Reset in the middle of a note computation.
        note_event(1'b1, 127);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", nif.note_ready, 1);
        check("midrst_gate", gate, 0);
        check("midrst_phase", phase, 0);
        #2 reset = 1'b1;
        @(negedge clk);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            sample_tick    = ($urandom_range(0, 3) == 0);
            nif.note_valid = ($urandom_range(0, 15) == 0);
            nif.note_on    = ($urandom_range(0, 3) != 0);
            nif.note_num   = 7'($urandom_range(0, 127));
            @(negedge clk);
        end
        nif.note_valid = 1'b0;
        sample_tick    = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
